sirv_pwm_deadtime: RTL and testbench
====================================

// Module: sirv_pwm_deadtime
// PURPOSE
//  Complementary-output stage fed by the gpio outputs of the 4-channel PWM core.
//  Turns each PWM level into a high-side/low-side pair with programmable dead time.
//  Absorbs input pulses shorter than the dead time.
//  Adds a latched fault shutdown and per-channel output polarity.
//  Sits between the PWM core and the IOF pad mux.
// PARAMETERS
//  NCH  4  channel count (1..4); config fields keep the 4-channel layout
//  DTW  8  dead-time counter width (1..8)
// PORTS
//  clock               in   1    single clock; io_pwm_in and io_fault are synchronous to it
//  reset               in   1    synchronous, active-high reset
//  io_cfg_write_valid  in   1    config register write strobe
//  io_cfg_write_bits   in   32   [DTW-1:0] dt, [11:8] en, [15:12] pol, [16] fault clear (write-1)
//  io_cfg_read         out  32   {fault, 14'b0, 1'b0, pol, en, dt zero-extended to 8b}
//  io_pwm_in           in   NCH  PWM levels (PWM core io_gpio_0..3)
//  io_fault            in   1    external fault request, level
//  io_hs               out  NCH  high-side drive
//  io_ls               out  NCH  low-side drive
//  io_fault_ip         out  1    fault latched (interrupt)
// BEHAVIOUR
//  Reset: cfg fields 0; fault latch 0; all channels IDLE; io_hs = io_ls = 0; io_fault_ip = 0.
//  Config write: dt, en, pol update on the write edge.
//   - New dt applies at the next counter load; a count in progress is not reloaded.
//   - Read returns the registered fields (no bypass).
//  Per-channel FSM; the state is registered, count cnt is DTW bits, input sampled each edge:
//   IDLE:    en=1 & !fault -> DEAD_LH if in=1, else DEAD_HL; cnt <= dt.
//   HIGH:    in=0 -> DEAD_HL, cnt <= dt.
//   LOW:     in=1 -> DEAD_LH, cnt <= dt.
//   DEAD_HL: in=1 -> HIGH (pulse absorbed); else cnt==0 -> LOW; else cnt--.
//   DEAD_LH: in=0 -> LOW (pulse absorbed); else cnt==0 -> HIGH; else cnt--.
//   Any state: en=0 or fault latched -> IDLE next edge; this has priority over all other transitions.
//  Raw outputs: hs_raw = (state==HIGH), ls_raw = (state==LOW); both are 0 in IDLE and DEAD states.
//  io_hs = hs_raw ^ pol[i], io_ls = ls_raw ^ pol[i]; decoded from state only (glitch-free).
//  Timing for an input edge sampled at edge N:
//   - The old side deasserts after N.
//   - The new side asserts after edge N+dt+1, i.e. both sides inactive for exactly dt+1 cycles.
//   - dt=0 still gives 1 dead cycle.
//   - hs_raw and ls_raw are never both 1.
//  Fault latch: set when io_fault=1 at an edge; cleared on a cfg write with bit16=1 while io_fault=0.
//   - Fault and clear on the same edge: fault wins.
//   - io_fault_ip = latch; io_cfg_read[31] = latch.
//   - After a clear, enabled channels restart from IDLE through a DEAD state (full dead time).
//  Disabling a channel (en=0) or raising a fault mid-DEAD drops the count; re-entry starts fresh.
//  Channels NCH..3: en/pol bits are stored and read back, but have no output.
//  reset has priority over everything; asserted mid-operation, all state returns to reset values next edge.
// TESTING
//  T1 dt=3, en=1, ch0 settled LOW, in0 0->1 sampled at edge N:
//     -> ls0=0 after N; hs0=1 after N+4; hs0 & ls0 never both 1.
//  T2 dt=5, ch0 HIGH, in0 low for 3 cycles:
//     -> hs0 low exactly 3 cycles; ls0 never asserts; returns to HIGH without dead delay.
//  T3 dt=0, in0 toggling every 4 cycles:
//     -> each transition has exactly 1 cycle with hs0=ls0=0; active phases are 3 cycles.
//  T4 all ch HIGH/LOW, 1-cycle io_fault pulse:
//     -> all outputs inactive next edge; io_fault_ip=1; read[31]=1.
//     Clear written while io_fault=1 -> latch stays 1.
//     Clear written with io_fault=0 -> latch 0, channels reach HIGH/LOW after dt+1 cycles.
//  T5 pol=4'b0101, en=0:
//     -> io_hs=io_ls=4'b0101. Then en=4'hf, dt=2, in=4'hf -> io_hs=4'b1010 after 3 cycles.
//  T6 reset asserted in DEAD_HL with cnt=4:
//     -> after the edge, outputs 0, io_cfg_read=0; after deassert, no output until cfg is rewritten.

Source files
------------

// File: rtl/sirv_pwm_deadtime.sv
// Complementary high/low-side drive from PWM levels with programmable dead time, fault latch and polarity.
// Outputs are registered state decodes (1 cycle after the sampled input); no flow control, every cycle is live.
module sirv_pwm_deadtime #(
    parameter int NCH = 4,
    parameter int DTW = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            io_cfg_write_valid,
    input  logic [31:0]     io_cfg_write_bits,
    output logic [31:0]     io_cfg_read,
    input  logic [NCH-1:0]  io_pwm_in,
    input  logic            io_fault,
    output logic [NCH-1:0]  io_hs,
    output logic [NCH-1:0]  io_ls,
    output logic            io_fault_ip
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HIGH,
        S_LOW,
        S_DEAD_HL,
        S_DEAD_LH
    } state_t;

    logic [DTW-1:0] dt;
    logic [3:0]     en;
    logic [3:0]     pol;
    logic           fault;

    state_t         st      [NCH];
    state_t         st_nxt  [NCH];
    logic [DTW-1:0] cnt     [NCH];
    logic [DTW-1:0] cnt_nxt [NCH];

    logic unused_cfg;
    assign unused_cfg = ^{io_cfg_write_bits[31:17], io_cfg_write_bits[7:0]};

    // A clear coinciding with a live fault request leaves the latch set.
    always_ff @(posedge clock) begin
        if (reset) begin
            dt    <= '0;
            en    <= '0;
            pol   <= '0;
            fault <= 1'b0;
        end else begin
            if (io_cfg_write_valid) begin
                dt  <= io_cfg_write_bits[DTW-1:0];
                en  <= io_cfg_write_bits[11:8];
                pol <= io_cfg_write_bits[15:12];
            end
            fault <= io_fault | (fault & ~(io_cfg_write_valid & io_cfg_write_bits[16]));
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            st_nxt[i]  = st[i];
            cnt_nxt[i] = cnt[i];
            if (!en[i] || fault) begin
                st_nxt[i] = S_IDLE;
            end else begin
                case (st[i])
                    S_IDLE: begin
                        st_nxt[i]  = io_pwm_in[i] ? S_DEAD_LH : S_DEAD_HL;
                        cnt_nxt[i] = dt;
                    end
                    S_HIGH: begin
                        if (!io_pwm_in[i]) begin
                            st_nxt[i]  = S_DEAD_HL;
                            cnt_nxt[i] = dt;
                        end
                    end
                    S_LOW: begin
                        if (io_pwm_in[i]) begin
                            st_nxt[i]  = S_DEAD_LH;
                            cnt_nxt[i] = dt;
                        end
                    end
                    // A reversal during dead time returns to the old side with no extra delay.
                    S_DEAD_HL: begin
                        if (io_pwm_in[i])        st_nxt[i]  = S_HIGH;
                        else if (cnt[i] == '0)   st_nxt[i]  = S_LOW;
                        else                     cnt_nxt[i] = cnt[i] - DTW'(1);
                    end
                    S_DEAD_LH: begin
                        if (!io_pwm_in[i])       st_nxt[i]  = S_LOW;
                        else if (cnt[i] == '0)   st_nxt[i]  = S_HIGH;
                        else                     cnt_nxt[i] = cnt[i] - DTW'(1);
                    end
                    default: st_nxt[i] = S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < NCH; i++) begin
            if (reset) begin
                st[i]  <= S_IDLE;
                cnt[i] <= '0;
            end else begin
                st[i]  <= st_nxt[i];
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            io_hs[i] = (st[i] == S_HIGH) ^ pol[i];
            io_ls[i] = (st[i] == S_LOW) ^ pol[i];
        end
    end

    assign io_cfg_read = {fault, 15'b0, pol, en, 8'(dt)};
    assign io_fault_ip = fault;

endmodule

// File: tb/tb_sirv_pwm_deadtime.sv
// Scoreboard bench for sirv_pwm_deadtime: directed scenarios plus random traffic vs. a behavioural model.
module tb_sirv_pwm_deadtime;

    logic        clock;
    logic        reset;
    logic        io_cfg_write_valid;
    logic [31:0] io_cfg_write_bits;
    logic [31:0] io_cfg_read;
    logic [3:0]  io_pwm_in;
    logic        io_fault;
    logic [3:0]  io_hs;
    logic [3:0]  io_ls;
    logic        io_fault_ip;

    sirv_pwm_deadtime #(.NCH(4), .DTW(8)) dut (
        .clock              (clock),
        .reset              (reset),
        .io_cfg_write_valid (io_cfg_write_valid),
        .io_cfg_write_bits  (io_cfg_write_bits),
        .io_cfg_read        (io_cfg_read),
        .io_pwm_in          (io_pwm_in),
        .io_fault           (io_fault),
        .io_hs              (io_hs),
        .io_ls              (io_ls),
        .io_fault_ip        (io_fault_ip)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic [3:0]  hs;
        logic [3:0]  ls;
        logic        fip;
        logic [31:0] rd;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Model: which side drives (0 none, 1 high, 2 low), whether the channel is parked,
    // how many more dead cycles remain, and which side the dead interval leads to.
    int       m_side [4];
    bit       m_idle [4];
    int       m_left [4];
    bit       m_tgt  [4];
    int       m_dt;
    bit [3:0] m_en;
    bit [3:0] m_pol;
    bit       m_fault;

    task automatic step(input bit r, input bit wr, input logic [31:0] wb,
                        input logic [3:0] pin, input bit f);
        exp_t e;
        @(negedge clock);
        reset              = r;
        io_cfg_write_valid = wr;
        io_cfg_write_bits  = wb;
        io_pwm_in          = pin;
        io_fault           = f;
        if (r) begin
            for (int i = 0; i < 4; i++) begin
                m_side[i] = 0; m_idle[i] = 1; m_left[i] = 0; m_tgt[i] = 0;
            end
            m_dt = 0; m_en = 0; m_pol = 0; m_fault = 0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!m_en[i] || m_fault) begin
                    m_idle[i] = 1; m_side[i] = 0;
                end else if (m_idle[i]) begin
                    m_idle[i] = 0; m_side[i] = 0; m_tgt[i] = pin[i]; m_left[i] = m_dt;
                end else if (m_side[i] != 0) begin
                    if (pin[i] != (m_side[i] == 1)) begin
                        m_side[i] = 0; m_tgt[i] = pin[i]; m_left[i] = m_dt;
                    end
                end else if (pin[i] != m_tgt[i]) begin
                    m_side[i] = pin[i] ? 1 : 2;
                end else if (m_left[i] == 0) begin
                    m_side[i] = m_tgt[i] ? 1 : 2;
                end else begin
                    m_left[i] = m_left[i] - 1;
                end
            end
            m_fault = f || (m_fault && !(wr && wb[16]));
            if (wr) begin
                m_dt = int'(wb[7:0]); m_en = wb[11:8]; m_pol = wb[15:12];
            end
        end
        for (int i = 0; i < 4; i++) begin
            e.hs[i] = (m_side[i] == 1) ^ m_pol[i];
            e.ls[i] = (m_side[i] == 2) ^ m_pol[i];
        end
        e.fip = m_fault;
        e.rd  = {m_fault, 15'b0, m_pol, m_en, 8'(m_dt)};
        exp_q.push_back(e);
    endtask

    task automatic run(input int n, input logic [3:0] pin);
        for (int k = 0; k < n; k++) step(0, 0, 32'h0, pin, 0);
    endtask

    task automatic wcfg(input logic [31:0] wb, input logic [3:0] pin, input bit f);
        step(0, 1, wb, pin, f);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_tests += 4;
                if (io_hs !== e.hs) begin
                    n_fail++; $display("FAIL hs got %b want %b at %0t", io_hs, e.hs, $time);
                end
                if (io_ls !== e.ls) begin
                    n_fail++; $display("FAIL ls got %b want %b at %0t", io_ls, e.ls, $time);
                end
                if (io_fault_ip !== e.fip) begin
                    n_fail++; $display("FAIL fault_ip got %b want %b at %0t", io_fault_ip, e.fip, $time);
                end
                if (io_cfg_read !== e.rd) begin
                    n_fail++; $display("FAIL cfg_read got %h want %h at %0t", io_cfg_read, e.rd, $time);
                end
            end
        end
    end

    initial begin : driver
        logic [31:0] wb;
        logic [3:0]  pin;
        reset = 1'b1; io_cfg_write_valid = 1'b0; io_cfg_write_bits = '0;
        io_pwm_in = '0; io_fault = 1'b0;
        step(1, 0, 32'h0, 4'h0, 0);
        step(1, 0, 32'h0, 4'h0, 0);

        // dead time 3 on a rising edge from a settled low side
        wcfg(32'h0000_0103, 4'h0, 0);
        run(8, 4'h0);
        run(8, 4'h1);
        // short low pulse on a settled high side is absorbed
        wcfg(32'h0000_0105, 4'h1, 0);
        run(10, 4'h1);
        run(3, 4'h0);
        run(6, 4'h1);
        // dt=0 with a 4-cycle toggle
        wcfg(32'h0000_0100, 4'h1, 0);
        for (int k = 0; k < 6; k++) run(4, (k % 2 == 0) ? 4'h0 : 4'h1);
        // fault pulse, blocked clear, effective clear
        wcfg(32'h0000_0F02, 4'h5, 0);
        run(6, 4'h5);
        step(0, 0, 32'h0, 4'h5, 1);
        run(3, 4'h5);
        wcfg(32'h0001_0F02, 4'h5, 1);
        run(2, 4'h5);
        wcfg(32'h0001_0F02, 4'h5, 0);
        run(6, 4'h5);
        // polarity on parked channels, then enable
        wcfg(32'h0000_5000, 4'h0, 0);
        run(3, 4'h0);
        wcfg(32'h0000_5F02, 4'hF, 0);
        run(5, 4'hF);
        // reset mid dead interval, no rewrite afterwards
        wcfg(32'h0000_0106, 4'h1, 0);
        run(10, 4'h1);
        run(3, 4'h0);
        step(1, 0, 32'h0, 4'h0, 0);
        run(5, 4'h1);

        pin = 4'h0;
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 3) == 0) pin[i] = ~pin[i];
            if ($urandom_range(0, 299) == 0) begin
                step(1, 0, 32'h0, pin, 0);
            end else if ($urandom_range(0, 24) == 0) begin
                wb = $urandom;
                wb[7:0] = 8'($urandom_range(0, 5));
                wb[11:8] = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
                wb[16] = ($urandom_range(0, 1) == 0);
                step(0, 1, wb, pin, ($urandom_range(0, 3) == 0));
            end else begin
                step(0, 0, 32'h0, pin, ($urandom_range(0, 79) == 0));
            end
        end

        repeat (3) @(negedge clock);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
